// File: rtl/multi_debouncer.sv
// Multi-channel switch debouncer: per-channel synchroniser followed by either a
// stability-window filter (MODE 0) or an accept-then-lockout filter (MODE 1).
module multi_debouncer #(
    parameter int   CHANNELS      = 4,
    parameter int   STABLE_CYCLES = 16,
    parameter int   SYNC_STAGES   = 2,
    parameter int   MODE          = 0,
    parameter logic INIT          = 1'b0
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                tick,
    input  logic [CHANNELS-1:0] sw_in,
    output logic [CHANNELS-1:0] out,
    output logic [CHANNELS-1:0] rise,
    output logic [CHANNELS-1:0] fall,
    output logic                any_change
);

    localparam int             CW   = $clog2(STABLE_CYCLES + 1);
    localparam logic [CW-1:0]  LAST = CW'(STABLE_CYCLES - 1);
    localparam logic [CW-1:0]  FULL = CW'(STABLE_CYCLES);
    localparam logic [CW-1:0]  ONE  = CW'(1);

    logic [CHANNELS-1:0] out_nxt;
    logic                any_q;

    for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
        logic [SYNC_STAGES-1:0] sync_q;
        logic                   s;
        logic [CW-1:0]          cnt_q;
        logic [CW-1:0]          cnt_d;
        logic                   out_q;
        logic                   out_d;
        logic                   rise_q;
        logic                   fall_q;

        // Synchroniser runs every clock; tick only gates the filter counters.
        always_ff @(posedge clock) begin
            if (reset) begin
                sync_q <= {SYNC_STAGES{INIT}};
            end else begin
                sync_q <= (sync_q << 1) | SYNC_STAGES'(sw_in[g]);
            end
        end

        assign s = sync_q[SYNC_STAGES-1];

        always_comb begin
            cnt_d = cnt_q;
            out_d = out_q;
            if (MODE == 0) begin
                if (s == out_q) begin
                    cnt_d = '0;
                end else if (tick) begin
                    if (cnt_q == LAST) begin
                        out_d = s;
                        cnt_d = '0;
                    end else begin
                        cnt_d = cnt_q + ONE;
                    end
                end
            end else begin
                // Accept immediately when idle, then ignore s until the lockout drains.
                if (cnt_q == '0) begin
                    if (s != out_q) begin
                        out_d = s;
                        cnt_d = FULL;
                    end
                end else if (tick) begin
                    cnt_d = cnt_q - ONE;
                end
            end
        end

        always_ff @(posedge clock) begin
            if (reset) begin
                cnt_q  <= '0;
                out_q  <= INIT;
                rise_q <= 1'b0;
                fall_q <= 1'b0;
            end else begin
                cnt_q  <= cnt_d;
                out_q  <= out_d;
                rise_q <= out_d & ~out_q;
                fall_q <= ~out_d & out_q;
            end
        end

        assign out[g]     = out_q;
        assign rise[g]    = rise_q;
        assign fall[g]    = fall_q;
        assign out_nxt[g] = out_d;
    end

    // Registered alongside the per-channel pulses so all three line up.
    always_ff @(posedge clock) begin
        if (reset) begin
            any_q <= 1'b0;
        end else begin
            any_q <= |(out_nxt ^ out);
        end
    end

    assign any_change = any_q;

endmodule
